instr_mem_loader: RTL

- Byte-stream program loader; the write side of the single-cycle core's instruction memory.
- Receives a framed program over an 8-bit valid/ready stream: count byte, instruction bytes, then XOR checksum byte.
- Assembles 32-bit little-endian words and drives the instruction-memory write port.
- Holds the core in reset while loading; releases it only after a verified load.

---
 rtl/instr_mem_loader_if.sv | 25 ++
 rtl/instr_mem_loader.sv | 135 +++++++++++++
 2 files changed

// File: rtl/instr_mem_loader_if.sv
// Program-load bus: the 8-bit byte stream into the loader and the
// instruction-memory write port out of it.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;

  // Byte source / memory observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wd
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader. Accepts a frame of
//   count byte N, 4*N instruction bytes (little-endian words), XOR checksum byte
// writes each assembled word into instruction memory, and keeps the core in
// reset until a load has been verified.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam int unsigned CAP = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            count;
  logic [7:0]            checksum;
  logic [1:0]            byte_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [23:0]           word_lo;
  logic                  fire;
  logic                  count_ok;
  logic                  last_word;

  // Bytes are only taken in the states that consume stream data; WRITE stalls
  assign bus.in_ready = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign bus.mem_we   = (state == WRITE);
  assign busy         = (state != IDLE);
  assign fire         = bus.in_valid && bus.in_ready;

  // N = 2**ADDR_WIDTH fills memory exactly and is legal
  assign count_ok  = (bus.in_data != 8'd0) && (32'(bus.in_data) <= CAP);
  assign last_word = ((32'(word_idx) + 32'd1) == 32'(count));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = COUNT;
      COUNT: if (bus.in_valid) state_nxt = count_ok ? DATA : IDLE;
      DATA:  if (bus.in_valid && (byte_idx == 2'd3)) state_nxt = WRITE;
      WRITE: state_nxt = last_word ? CHECK : DATA;
      CHECK: if (bus.in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word assembly, checksum, write port and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count        <= '0;
      checksum     <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      word_lo      <= '0;
      bus.mem_addr <= '0;
      bus.mem_wd   <= '0;
      core_rst     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            core_rst     <= 1'b1;
          end
        end
        COUNT: begin
          if (fire) begin
            if (count_ok) begin
              count    <= bus.in_data;
              byte_idx <= '0;
              word_idx <= '0;
              checksum <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (fire) begin
            checksum <= checksum ^ bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_lo[7:0]   <= bus.in_data;
              2'd1: word_lo[15:8]  <= bus.in_data;
              2'd2: word_lo[23:16] <= bus.in_data;
              default: begin
                // Present the finished word now so it is stable during WRITE
                bus.mem_wd   <= DATA_WIDTH'({bus.in_data, word_lo});
                bus.mem_addr <= word_idx;
              end
            endcase
          end
        end
        WRITE: begin
          word_idx     <= word_idx + ADDR_WIDTH'(1);
          words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
        end
        CHECK: begin
          if (fire) begin
            if (bus.in_data == checksum) begin
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
